// File: rtl/rs485_tx.sv
// UART-style RS485 transmitter: start bit, LSB-first data, optional parity, stop bit(s),
// with driver-enable guard times before and after the frame. One bit = OVS bclk cycles.
module rs485_tx #(
  parameter int unsigned OVS        = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DE_LEAD    = 16,
  parameter int unsigned DE_LAG     = 16
) (
  input  logic                 bclk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_din,
  output logic                 txd,
  output logic                 tx_de,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CntMax1 = (OVS > DE_LEAD) ? OVS : DE_LEAD;
  localparam int unsigned CntMax  = (CntMax1 > DE_LAG) ? CntMax1 : DE_LAG;
  localparam int unsigned CntW    = $clog2(CntMax);
  localparam int unsigned BitW    = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] OvsLast  = CntW'(OVS - 1);
  localparam logic [CntW-1:0] LeadLast = CntW'((DE_LEAD > 0) ? DE_LEAD - 1 : 0);
  localparam logic [CntW-1:0] LagLast  = CntW'((DE_LAG > 0) ? DE_LAG - 1 : 0);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);
  localparam logic            ParOdd   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle, StLead, StStart, StData, StParity, StStop, StLag
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   par_q, par_d;
  logic                   pend_q, pend_d;
  logic                   txd_q, txd_d;
  logic                   de_q, de_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   finish;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pend_d  = 1'b0;
    done_d  = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // pend_q marks the cycle between acceptance and the first driven cycle
        if (pend_q) begin
          state_d = (DE_LEAD > 0) ? StLead : StStart;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      StLead: begin
        if (cnt_q == LeadLast) begin
          state_d = StStart;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == OvsLast) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == OvsLast) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          if (bit_q == DataLast) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (cnt_q == OvsLast) begin
          state_d = StStop;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == OvsLast) begin
          cnt_d = '0;
          if (bit_q == StopLast) begin
            bit_d = '0;
            if (DE_LAG > 0) begin
              state_d = StLag;
            end else begin
              finish = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLag: begin
        if (cnt_q == LagLast) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      state_d = StIdle;
      cnt_d   = '0;
      done_d  = 1'b1;
    end

    // The completing edge may also accept, so held requests give back-to-back frames
    if (tx_start && ((state_q == StIdle && !pend_q) || finish)) begin
      sh_d   = tx_din;
      par_d  = (^tx_din) ^ ParOdd;
      pend_d = 1'b1;
    end

    busy_d = (state_d != StIdle);
    de_d   = (state_d != StIdle);
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = sh_d[0];
      StParity: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pend_q  <= 1'b0;
      txd_q   <= 1'b1;
      de_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      pend_q  <= pend_d;
      txd_q   <= txd_d;
      de_q    <= de_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign txd     = txd_q;
  assign tx_de   = de_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_rs485_tx.sv
// Scoreboarded bench for rs485_tx: two instances (8N1 default, and 8E2 with no DE guard),
// random bytes, ignored mid-frame requests, back-to-back frames and a mid-frame reset.
module tb_rs485_tx;

  logic       bclk = 1'b0;
  logic       reset;
  logic [1:0] start_w;
  logic [7:0] din0, din1;
  logic [1:0] txd_w, de_w, busy_w, done_w;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 bclk = ~bclk;

  rs485_tx u_dut0 (
    .bclk(bclk), .reset(reset), .tx_start(start_w[0]), .tx_din(din0),
    .txd(txd_w[0]), .tx_de(de_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  rs485_tx #(
    .OVS(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2),
    .DE_LEAD(0), .DE_LAG(0)
  ) u_dut1 (
    .bclk(bclk), .reset(reset), .tx_start(start_w[1]), .tx_din(din1),
    .txd(txd_w[1]), .tx_de(de_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int idx, input logic s, input logic [7:0] d);
    if (idx == 0) begin
      start_w[0] = s;
      din0       = d;
    end else begin
      start_w[1] = s;
      din1       = d;
    end
  endtask

  // Frame length in bclk cycles from first tx_de-high cycle to the tx_done cycle
  function automatic int frame_len(input int ovs, input int lead, input int lag,
                                   input int pen, input int stops);
    return lead + (1 + 8 + pen + stops) * ovs + lag;
  endfunction

  task automatic drive(input int idx, input int len, input int nfr);
    logic [7:0] d;
    int gap, noise;
    bit hold;
    @(negedge bclk);
    for (int n = 0; n < nfr; n++) begin
      d = 8'($urandom);
      set_in(idx, 1'b1, d);
      @(posedge bclk);
      if (idx == 0) q0.push_back(d);
      else          q1.push_back(d);
      hold  = ($urandom_range(0, 3) == 0);
      gap   = hold ? 0 : $urandom_range(0, 3);
      noise = $urandom_range(1, len);
      for (int c = 1; c <= len + gap; c++) begin
        @(negedge bclk);
        set_in(idx, hold || (c == noise), 8'($urandom));
      end
      @(negedge bclk);
    end
    set_in(idx, 1'b0, 8'h00);
  endtask

  task automatic monitor(input int idx, input int ovs, input int lead, input int lag,
                         input int pen, input int stops);
    int nbits, len, e, werr, derr, berr, xerr;
    logic [15:0] fb;
    logic [7:0]  exp_d, got;
    nbits = 1 + 8 + pen + stops;
    len   = frame_len(ovs, lead, lag, pen, stops);
    forever begin
      @(negedge bclk);
      if (done_w[idx]) chk($sformatf("d%0d_spurious_done", idx), 1, 0);
      if (de_w[idx]) begin
        if (idx == 0 && q0.size() > 0)      exp_d = q0.pop_front();
        else if (idx == 1 && q1.size() > 0) exp_d = q1.pop_front();
        else begin
          chk($sformatf("d%0d_unexpected_frame", idx), 1, 0);
          exp_d = 8'h00;
        end
        fb    = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = exp_d[i];
        if (pen != 0) fb[9] = ^exp_d;
        werr = 0; derr = 0; berr = 0; xerr = 0; got = '0;
        for (int t = 0; t < len; t++) begin
          if (t > 0) @(negedge bclk);
          if (t < lead || t >= lead + nbits * ovs) e = 1;
          else e = int'(fb[(t - lead) / ovs]);
          if (int'(txd_w[idx]) != e) werr++;
          if (de_w[idx] !== 1'b1) derr++;
          if (busy_w[idx] !== 1'b1) berr++;
          if (done_w[idx] !== 1'b0) xerr++;
          for (int i = 0; i < 8; i++)
            if (t == lead + (1 + i) * ovs + ovs / 2) got[i] = txd_w[idx];
        end
        @(negedge bclk);
        chk($sformatf("d%0d_done_pulse", idx), int'(done_w[idx]), 1);
        chk($sformatf("d%0d_de_low_at_done", idx), int'(de_w[idx]), 0);
        chk($sformatf("d%0d_busy_low_at_done", idx), int'(busy_w[idx]), 0);
        chk($sformatf("d%0d_txd_idle_at_done", idx), int'(txd_w[idx]), 1);
        chk($sformatf("d%0d_txd_wave_errs", idx), werr, 0);
        chk($sformatf("d%0d_de_gaps", idx), derr, 0);
        chk($sformatf("d%0d_busy_gaps", idx), berr, 0);
        chk($sformatf("d%0d_early_done", idx), xerr, 0);
        chk($sformatf("d%0d_byte_decoded", idx), int'(got), int'(exp_d));
      end
    end
  endtask

  int len0, len1, seen_de, seen_done;

  initial begin
    len0 = frame_len(16, 16, 16, 0, 1);
    len1 = frame_len(16, 0, 0, 1, 2);
    chk("len0_default_busy_window", len0, 192);
    reset   = 1'b1;
    start_w = 2'b00;
    din0    = 8'h00;
    din1    = 8'h00;
    repeat (3) @(posedge bclk);
    @(negedge bclk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_txd", i), int'(txd_w[i]), 1);
      chk($sformatf("rst%0d_de", i), int'(de_w[i]), 0);
      chk($sformatf("rst%0d_busy", i), int'(busy_w[i]), 0);
      chk($sformatf("rst%0d_done", i), int'(done_w[i]), 0);
    end
    reset = 1'b0;

    // Mid-frame reset: accept at edge k, reset sampled at edge k+80
    start_w = 2'b11;
    din0    = 8'h3C;
    din1    = 8'h3C;
    @(posedge bclk);
    @(negedge bclk);
    start_w = 2'b00;
    repeat (79) @(negedge bclk);
    reset = 1'b1;
    @(negedge bclk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mrst%0d_txd", i), int'(txd_w[i]), 1);
      chk($sformatf("mrst%0d_de", i), int'(de_w[i]), 0);
      chk($sformatf("mrst%0d_busy", i), int'(busy_w[i]), 0);
    end
    seen_de   = 0;
    seen_done = 0;
    repeat (250) begin
      @(negedge bclk);
      if (de_w != 2'b00) seen_de++;
      if (done_w != 2'b00) seen_done++;
    end
    chk("mrst_no_done_after_abort", seen_done, 0);
    chk("mrst_no_de_after_abort", seen_de, 0);

    fork
      monitor(0, 16, 16, 16, 0, 1);
      monitor(1, 16, 0, 0, 1, 2);
    join_none

    fork
      drive(0, len0, 12);
      drive(1, len1, 12);
    join

    for (int i = 0; i < 2000 && (q0.size() + q1.size()) > 0; i++) @(negedge bclk);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    repeat (len0 + 20) @(negedge bclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
